// File: rtl/pc_seq_unit.sv
// Program-counter unit: auto-increment, PC-relative branch, bus load, and a
// hardware return-address stack for call/ret. Drives the shared bus one cycle after pc_out.
module pc_seq_unit #(
  parameter int               W       = 32,
  parameter int               INC     = 4,
  parameter logic [W-1:0]     RST_VEC = '0,
  parameter int               DEPTH   = 4,
  localparam int              CW      = $clog2(DEPTH + 1),
  localparam int              PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pc_in,
  input  logic          pc_out,
  input  logic          pc_inc,
  input  logic          pc_rel,
  input  logic          call,
  input  logic          ret,
  inout  wire  [W-1:0]  bus,
  output logic [W-1:0]  pc,
  output logic [CW-1:0] stk_cnt,
  output logic          stk_full,
  output logic          stk_empty,
  output logic          stk_err
);

  logic [W-1:0]  stack [DEPTH];
  logic          out_q;

  logic [W-1:0]  pc_nxt;
  logic [CW-1:0] cnt_nxt;
  logic          err_nxt;
  logic          push;
  logic [PW-1:0] push_idx;
  logic [PW-1:0] top_idx;
  logic [W-1:0]  ret_addr;

  assign bus       = out_q ? pc : 'z;
  assign stk_full  = (stk_cnt == CW'(DEPTH));
  assign stk_empty = (stk_cnt == '0);

  assign push_idx = PW'(stk_cnt);
  assign top_idx  = PW'(stk_cnt - 1'b1);
  assign ret_addr = pc + W'(INC);

  // Only one PC-changing op per cycle: ret > call > pc_in > pc_rel > pc_inc.
  // NOTE: every signal gets a default at the top of always_comb, so no branch can infer a latch.
  always_comb begin
    pc_nxt  = pc;
    cnt_nxt = stk_cnt;
    err_nxt = stk_err;
    push    = 1'b0;
    if (ret) begin
      if (stk_empty) begin
        err_nxt = 1'b1;
      end else begin
        pc_nxt  = stack[top_idx];
        cnt_nxt = stk_cnt - 1'b1;
      end
    end else if (call) begin
      pc_nxt = bus;
      if (stk_full) begin
        err_nxt = 1'b1;
      end else begin
        push    = 1'b1;
        cnt_nxt = stk_cnt + 1'b1;
      end
    end else if (pc_in) begin
      pc_nxt = bus;
    end else if (pc_rel) begin
      // Unsigned W-bit add is the same as adding a two's-complement offset.
      pc_nxt = pc + bus;
    end else if (pc_inc) begin
      pc_nxt = pc + W'(INC);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= RST_VEC;
      stk_cnt <= '0;
      stk_err <= 1'b0;
      out_q   <= 1'b0;
    end else begin
      pc      <= pc_nxt;
      stk_cnt <= cnt_nxt;
      stk_err <= err_nxt;
      out_q   <= pc_out;
    end
  end

  // NOTE: stack storage is not reset; entries above stk_cnt are never read, so a reset adds nothing.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      stack[push_idx] <= ret_addr;
    end
  end

endmodule

// File: tb/tb_pc_seq_unit.sv
// Self-checking bench for pc_seq_unit: directed scenarios plus random strobes,
// compared every cycle against a queue-based reference model.
module tb_pc_seq_unit;
  localparam int W     = 32;
  localparam int INC   = 4;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst, pc_in, pc_out, pc_inc, pc_rel, call, ret;
  logic          tb_en;
  logic [W-1:0]  tb_val;
  wire  [W-1:0]  bus;
  logic [W-1:0]  pc;
  logic [CW-1:0] stk_cnt;
  logic          stk_full, stk_empty, stk_err;

  assign bus = tb_en ? tb_val : 'z;

  pc_seq_unit #(.W(W), .INC(INC), .RST_VEC('0), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .pc_out(pc_out), .pc_inc(pc_inc),
    .pc_rel(pc_rel), .call(call), .ret(ret), .bus(bus), .pc(pc),
    .stk_cnt(stk_cnt), .stk_full(stk_full), .stk_empty(stk_empty), .stk_err(stk_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [W-1:0] m_pc;
  logic [W-1:0] m_stk[$];
  bit           m_err;
  bit           m_out;
  bit           m_known;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive strobes, check bus in the current cycle, advance model, check state.
  task automatic apply(input bit r, input bit rt, input bit cl, input bit pin,
                       input bit prel, input bit pinc, input bit pout,
                       input logic [W-1:0] val);
    logic [W-1:0] bv;
    rst = r; ret = rt; call = cl; pc_in = pin; pc_rel = prel; pc_inc = pinc; pc_out = pout;
    tb_val = val;
    tb_en  = !m_out;
    #1;
    if (m_known) begin
      if (m_out) check("bus_drive", bus, m_pc);
      else       check("bus_z", bus, val);
    end
    @(posedge clk);
    bv = m_out ? m_pc : val;
    if (r) begin
      m_pc = '0; m_stk.delete(); m_err = 0; m_out = 0; m_known = 1;
    end else begin
      if (rt) begin
        if (m_stk.size() == 0) m_err = 1;
        else m_pc = m_stk.pop_back();
      end else if (cl) begin
        if (m_stk.size() == DEPTH) m_err = 1;
        else m_stk.push_back(m_pc + W'(INC));
        m_pc = bv;
      end else if (pin)  m_pc = bv;
      else if (prel)     m_pc = m_pc + bv;
      else if (pinc)     m_pc = m_pc + W'(INC);
      m_out = pout;
    end
    #1;
    if (m_known) begin
      check("pc", pc, m_pc);
      check("stk_cnt", W'(stk_cnt), W'(m_stk.size()));
      check("stk_full", W'(stk_full), W'(m_stk.size() == DEPTH));
      check("stk_empty", W'(stk_empty), W'(m_stk.size() == 0));
      check("stk_err", W'(stk_err), W'(m_err));
    end
  endtask

  task automatic idle(input logic [W-1:0] val);
    apply(0, 0, 0, 0, 0, 0, 0, val);
  endtask

  initial begin
    rst = 0; ret = 0; call = 0; pc_in = 0; pc_rel = 0; pc_inc = 0; pc_out = 0;
    tb_en = 1; tb_val = '0;
    m_pc = '0; m_err = 0; m_out = 0; m_known = 0;
    @(posedge clk); #1;

    // 1: reset state and increment
    apply(1, 0, 0, 0, 0, 0, 0, 32'h0);
    check("t1_pc_rst", pc, 32'h0);
    check("t1_empty", W'(stk_empty), 32'h1);
    check("t1_err", W'(stk_err), 32'h0);
    idle(32'h5A5A_0000);
    repeat (3) apply(0, 0, 0, 0, 0, 1, 0, 32'h0);
    check("t1_pc_inc3", pc, 32'h0C);

    // 2: bus driven only the cycle after the pc_out strobe, then pc_in
    apply(0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFF0);
    idle(32'hFFFF_FFF0);
    idle(32'h0000_0100);
    apply(0, 0, 0, 1, 0, 0, 0, 32'h0000_0100);
    check("t2_pc_load", pc, 32'h100);

    // 3: negative relative branch and increment wrap
    apply(0, 0, 0, 0, 1, 0, 0, 32'hFFFF_FFF0);
    check("t3_pc_rel", pc, 32'hF0);
    apply(0, 0, 0, 1, 0, 0, 0, 32'hFFFF_FFFC);
    apply(0, 0, 0, 0, 0, 1, 0, 32'h0);
    check("t3_pc_wrap", pc, 32'h0);

    // 4: nested call/ret
    apply(0, 0, 0, 1, 0, 0, 0, 32'h40);
    apply(0, 0, 1, 0, 0, 0, 0, 32'h200);
    check("t4_call1_cnt", W'(stk_cnt), 32'h1);
    apply(0, 0, 1, 0, 0, 0, 0, 32'h300);
    check("t4_call2_pc", pc, 32'h300);
    apply(0, 1, 0, 0, 0, 0, 0, 32'h0);
    check("t4_ret1_pc", pc, 32'h204);
    apply(0, 1, 0, 0, 0, 0, 0, 32'h0);
    check("t4_ret2_pc", pc, 32'h44);
    check("t4_empty", W'(stk_empty), 32'h1);

    // 5: underflow then overflow
    apply(1, 0, 0, 0, 0, 0, 0, 32'h0);
    apply(0, 0, 0, 1, 0, 0, 0, 32'h88);
    apply(0, 1, 0, 0, 0, 0, 0, 32'h0);
    check("t5_uflow_pc", pc, 32'h88);
    check("t5_uflow_err", W'(stk_err), 32'h1);
    apply(1, 0, 0, 0, 0, 0, 0, 32'h0);
    for (int i = 1; i <= 5; i++) apply(0, 0, 1, 0, 0, 0, 0, W'(i) << 12);
    check("t5_full", W'(stk_full), 32'h1);
    check("t5_oflow_err", W'(stk_err), 32'h1);
    check("t5_oflow_pc", pc, 32'h5000);
    repeat (4) apply(0, 1, 0, 0, 0, 0, 0, 32'h0);
    check("t5_drain_pc", pc, 32'h4);

    // 6: priority and reset-over-call; self-drive into call
    apply(1, 0, 0, 0, 0, 0, 0, 32'h0);
    apply(0, 0, 1, 0, 0, 0, 0, 32'h700);
    apply(0, 1, 1, 0, 0, 1, 0, 32'h900);
    check("t6_prio_pc", pc, 32'h4);
    apply(0, 0, 0, 0, 0, 0, 1, 32'h0);
    apply(0, 0, 1, 0, 0, 0, 0, 32'h0);
    check("t6_selfdrive_pc", pc, 32'h4);
    apply(1, 0, 1, 0, 0, 0, 0, 32'h800);
    check("t6_rst_pc", pc, 32'h0);
    check("t6_rst_cnt", W'(stk_cnt), 32'h0);

    // Random strobes
    for (int n = 0; n < 800; n++) begin
      apply($urandom_range(0, 99) < 2,
            $urandom_range(0, 99) < 20,
            $urandom_range(0, 99) < 25,
            $urandom_range(0, 99) < 20,
            $urandom_range(0, 99) < 20,
            $urandom_range(0, 99) < 40,
            $urandom_range(0, 99) < 30,
            ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 255)) : W'($urandom()));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
